// File: rtl/lru_input_capture.sv
// Board-input front end: synchronises and debounces a push button, then snapshots the switch bank once per accepted press.
// Optional auto-repeat while the button is held is enabled by defining CAPTURE_AUTOREPEAT_EN.
module lru_input_capture #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic [WIDTH-1:0] sw_in,
  output logic             valid_data,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_CYCLES) ? CNT_MAX_A : REPEAT_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef CAPTURE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    EMIT,
    HOLD,
    RELEASE_DB
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_m_q, btn_m_d;
  logic             btn_s_q, btn_s_d;
  logic [WIDTH-1:0] sw_m_q, sw_m_d;
  logic [WIDTH-1:0] sw_s_q, sw_s_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // Two-flop synchronisers for the asynchronous button and switches
  always_comb begin
    btn_m_d = btn_in;
    btn_s_d = btn_m_q;
    sw_m_d  = sw_in;
    sw_s_d  = sw_m_q;
  end

  // Debounce / emit state machine; one shared counter, cleared on every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = EMIT;
          cnt_d   = '0;
          data_d  = sw_s_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      EMIT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!btn_s_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef CAPTURE_AUTOREPEAT_EN
        else if (cnt_q == RPT_LAST) begin
          state_d = EMIT;
          cnt_d   = '0;
          data_d  = sw_s_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      RELEASE_DB: begin
        if (btn_s_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they line up with state_q
    valid_d = (state_d == EMIT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
      sw_m_q  <= '0;
      sw_s_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_m_q <= btn_m_d;
      btn_s_q <= btn_s_d;
      sw_m_q  <= sw_m_d;
      sw_s_q  <= sw_s_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign valid_data = valid_q;
  assign data       = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lru_input_capture.sv
// Directed bench for lru_input_capture: vector table for reset/press/glitch/bounce,
// hand sequences for data stability, reset during an event and held-button behaviour.
module tb_lru_input_capture;

`ifdef CAPTURE_AUTOREPEAT_EN
  localparam bit AR         = 1'b1;
  localparam int EXP_EVENTS = 8;
`else
  localparam bit AR         = 1'b0;
  localparam int EXP_EVENTS = 6;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        btn_in = 1'b1;
  logic [11:0] sw_in  = 12'hFFF;
  logic        valid_data;
  logic [11:0] data;
  logic        busy;

  int total  = 0;
  int bad    = 0;
  int events = 0;

  lru_input_capture #(
    .WIDTH          (12),
    .DEBOUNCE_CYCLES(16),
    .PULSE_CYCLES   (2),
    .REPEAT_CYCLES  (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .valid_data(valid_data),
    .data      (data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        b;
    logic [11:0] sw;
    int          n;
    logic        ev;
    logic [11:0] ed;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic [11:0] sw, input int n,
                     input logic ev, input logic [11:0] ed, input logic eb);
    vec_t v;
    v.r = r; v.b = b; v.sw = sw; v.n = n; v.ev = ev; v.ed = ed; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Event monitor: counts rising edges of valid_data and checks pulse length
  initial begin
    int  len     = 0;
    bit  prev_v  = 1'b0;
    bit  aborted = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_data === 1'b1) begin
        if (!prev_v) events++;
        len++;
        if (rst) aborted = 1'b1;
      end else begin
        if (prev_v && !aborted) chk("pulse_len", 32'(len), 32'd2);
        len     = 0;
        aborted = 1'b0;
      end
      prev_v = (valid_data === 1'b1);
    end
  end

  initial begin
    // reset with button held and switches all ones
    add(1, 1, 12'hFFF,  1, 0, 12'h000, 0);
    add(1, 1, 12'hFFF,  2, 0, 12'h000, 0);
    add(0, 0, 12'hFFF,  2, 0, 12'h000, 0);
    // clean press, 40 cycles high
    add(0, 1, 12'hABC, 18, 0, 12'h000, 1);
    add(0, 1, 12'hABC,  1, 1, 12'hABC, 1);
    add(0, 1, 12'hABC,  1, 1, 12'hABC, 1);
    add(0, 1, 12'hABC,  1, 0, 12'hABC, 1);
    add(0, 1, 12'hABC, 19, 0, 12'hABC, 1);
    add(0, 0, 12'hABC, 18, 0, 12'hABC, 1);
    add(0, 0, 12'hABC,  1, 0, 12'hABC, 0);
    // glitch: 10 cycles high, switches changed
    add(0, 1, 12'h555, 10, 0, 12'hABC, 1);
    add(0, 0, 12'h555,  2, 0, 12'hABC, 1);
    add(0, 0, 12'h555,  1, 0, 12'hABC, 0);
    add(0, 0, 12'h555,  5, 0, 12'hABC, 0);
    // held press followed by release bounce
    add(0, 1, 12'h321, 40, 0, 12'h321, 1);
    add(0, 0, 12'h321,  5, 0, 12'h321, 1);
    add(0, 1, 12'h321,  5, 0, 12'h321, 1);
    add(0, 0, 12'h321,  5, 0, 12'h321, 1);
    add(0, 1, 12'h321,  5, 0, 12'h321, 1);
    add(0, 0, 12'h321,  5, 0, 12'h321, 1);
    add(0, 1, 12'h321,  5, 0, 12'h321, 1);
    add(0, 0, 12'h321, 25, 0, 12'h321, 0);

    foreach (tbl[i]) begin
      rst    = tbl[i].r;
      btn_in = tbl[i].b;
      sw_in  = tbl[i].sw;
      step(tbl[i].n);
      chk($sformatf("vec[%0d].valid", i), 32'(valid_data), 32'(tbl[i].ev));
      chk($sformatf("vec[%0d].data", i),  32'(data),       32'(tbl[i].ed));
      chk($sformatf("vec[%0d].busy", i),  32'(busy),       32'(tbl[i].eb));
    end
    chk("events_after_table", 32'(events), 32'd2);

    // switches change while the event is being emitted
    btn_in = 1'b1; sw_in = 12'h123;
    step(18);
    chk("stab.pre_valid", 32'(valid_data), 32'd0);
    step(1);
    chk("stab.valid0", 32'(valid_data), 32'd1);
    chk("stab.data0",  32'(data), 32'h123);
    sw_in = 12'h456;
    step(1);
    chk("stab.valid1", 32'(valid_data), 32'd1);
    chk("stab.data1",  32'(data), 32'h123);
    step(1);
    chk("stab.valid2", 32'(valid_data), 32'd0);
    step(10);
    chk("stab.data_hold", 32'(data), 32'h123);
    btn_in = 1'b0;
    step(25);
    chk("stab.data_rel", 32'(data), 32'h123);
    chk("stab.busy_rel", 32'(busy), 32'd0);

    // reset while emitting, button still held: fresh press follows
    btn_in = 1'b1;
    step(19);
    chk("rst_emit.valid", 32'(valid_data), 32'd1);
    chk("rst_emit.data",  32'(data), 32'h456);
    rst = 1'b1;
    step(1);
    chk("rst_emit.valid_r", 32'(valid_data), 32'd0);
    chk("rst_emit.data_r",  32'(data), 32'h000);
    chk("rst_emit.busy_r",  32'(busy), 32'd0);
    rst = 1'b0;
    step(18);
    chk("reemit.pre_valid", 32'(valid_data), 32'd0);
    chk("reemit.pre_busy",  32'(busy), 32'd1);
    chk("reemit.pre_data",  32'(data), 32'h000);
    step(1);
    chk("reemit.valid", 32'(valid_data), 32'd1);
    chk("reemit.data",  32'(data), 32'h456);
    step(2);
    chk("reemit.valid_end", 32'(valid_data), 32'd0);
    btn_in = 1'b0;
    step(25);
    chk("reemit.busy_rel", 32'(busy), 32'd0);

    // button held 200 cycles: auto-repeat when enabled, single event otherwise
    btn_in = 1'b1; sw_in = 12'h00F;
    for (int k = 0; k < 200; k++) begin
      logic ev;
      step(1);
      ev = (k == 18 || k == 19) ||
           (AR && (k == 84 || k == 85 || k == 150 || k == 151));
      chk($sformatf("hold.valid[%0d]", k), 32'(valid_data), 32'(ev));
    end
    chk("hold.data", 32'(data), 32'h00F);
    btn_in = 1'b0;
    step(25);
    chk("hold.busy_rel", 32'(busy), 32'd0);
    step(2);

    chk("events_total", 32'(events), 32'(EXP_EVENTS));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lru_input_capture.md
Name: lru_input_capture

Overview:
- Upstream front end for the 4-entry LRU buffer stage.
- Turns raw board inputs (one push button, WIDTH slide switches) into clean capture events. It synchronises and debounces the button, snapshots the switches once per accepted press, and presents the snapshot on data with a fixed-length valid_data level.
- The downstream LRU stage rising-edge-detects valid_data, so this block guarantees one clean rising edge per accepted press and a low gap between events.

Parameters:
WIDTH, 12, width of sw_in and data
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or release (>=1; board builds override to ~1_000_000)
PULSE_CYCLES, 2, cycles valid_data stays high per event (>=1)
REPEAT_CYCLES, 64, hold time before auto-repeat (>=2; used only with CAPTURE_AUTOREPEAT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_in  input  1  raw asynchronous push button, active high
sw_in  input  WIDTH  raw asynchronous switch bank
valid_data  output  1  registered; high for exactly PULSE_CYCLES cycles per accepted event
data  output  WIDTH  registered captured switch value; stable between captures
busy  output  1  registered; high whenever FSM is not IDLE

Behaviour:
- Reset is synchronous, active-high, on clock clk. rst has priority over all other logic.
- Reset values: state IDLE, all counters 0, sync flops 0, valid_data 0, data 0, busy 0.
- Synchronisers: two-flop synchroniser on btn_in; two-flop synchroniser on each sw_in bit. btn_s and sw_s are the second-stage outputs, giving 2 cycles of latency.
- IDLE:
  - btn_s=1 -> PRESS_DB, cnt<=0.
  - btn_s=0 -> stay.
- PRESS_DB:
  - btn_s=0 -> IDLE (glitch rejected, no event).
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> EMIT, data<=sw_s, cnt<=0.
  - Otherwise cnt<=cnt+1.
- EMIT:
  - valid_data=1 in every cycle state==EMIT.
  - cnt increments each cycle; after PULSE_CYCLES cycles -> HOLD, cnt<=0.
  - The button is ignored during EMIT.
- HOLD:
  - btn_s=0 -> RELEASE_DB, cnt<=0.
  - Otherwise stay (see Optional Feature).
- RELEASE_DB:
  - btn_s=1 -> HOLD (release bounce absorbed, no new event).
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt++.
- Latency: if btn_in is first sampled high at edge e0 and stays high, valid_data is high after edge e0+DEBOUNCE_CYCLES+2. data changes on the same edge and holds the sw_s value present one cycle earlier.
- data changes only on entry to EMIT; sw_in activity at any other time has no effect on data.
- valid_data is low for at least DEBOUNCE_CYCLES+2 cycles between consecutive events.
- busy = (state != IDLE).
- Counter width is sized for max(DEBOUNCE_CYCLES, PULSE_CYCLES, REPEAT_CYCLES). Counters never wrap; they are cleared on every state transition.
- Reset mid-operation (any state): outputs take reset values on the next edge.
  - If the button is still physically held, the block treats it as a fresh press and emits after the full debounce.
  - This re-emission is required behaviour.

Optional Feature:
- Macro: CAPTURE_AUTOREPEAT_EN.
- Defined:
  - In HOLD, a repeat counter increments while btn_s=1.
  - When it reaches REPEAT_CYCLES-1, the block transitions to EMIT with data<=sw_s (new snapshot), emitting another PULSE_CYCLES-long event.
  - The repeat counter is cleared on entering HOLD and on btn_s=0.
  - valid_data is therefore low for REPEAT_CYCLES cycles between repeats.
- Not defined: HOLD waits indefinitely for release; the repeat counter logic is absent; REPEAT_CYCLES is unused.

Test Plan:
1. Reset: assert rst 3 cycles with btn_in=1, sw_in=0xFFF -> valid_data=0, data=0x000, busy=0 during and immediately after reset.
2. Clean press: sw_in=0xABC, btn_in high 40 cycles from edge e0 -> valid_data high after edges e0+18 and e0+19 only, data=0xABC from e0+18, busy falls DEBOUNCE_CYCLES+2 cycles after btn_in low.
3. Glitch: btn_in high 10 cycles then low -> no valid_data; busy high then back to 0; data unchanged.
4. Bounce: press held 40 cycles, then btn_in toggles every 5 cycles for 30 cycles before going low -> exactly one valid_data event total.
5. Data stability: sw_in changes 0x123->0x456 during EMIT -> data stays 0x123 until the next press. Reset asserted in EMIT -> valid_data=0 and data=0 after that edge.
6. With CAPTURE_AUTOREPEAT_EN, btn held 200 cycles, sw_in=0x00F -> events at e0+18, e0+84, e0+150, each 2 cycles high, each followed by a 64-cycle low gap. Without the macro, the same stimulus gives a single event.
